// File: rtl/calc_key_entry.sv
// calc_key_entry: keypad entry FSM that collects BCD operands and an opcode for a multi-cycle ALU,
// then shows the result it returns.
module calc_key_entry #(
  parameter int ALU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  input  logic [15:0] res,
  output logic [15:0] num1,
  output logic [15:0] num2,
  output logic [2:0]  op,
  output logic        start,
  output logic        busy,
  output logic [15:0] disp
);
  typedef enum logic [1:0] {ENTER_A, ENTER_B, WAIT, SHOW} state_t;
  state_t state, state_n;
  logic [15:0] num1_n, num2_n, result, result_n;
  logic [2:0] op_n, cnt_a, cnt_a_n, cnt_b, cnt_b_n;
  logic [3:0] lat, lat_n;
  logic start_n, is_digit, is_op, is_eq, is_clr;
  logic [3:0] d;
  assign d = key_code[3:0];
  assign is_digit = key_valid && key_code < 5'd10;
  assign is_op = key_valid && key_code >= 5'd10 && key_code <= 5'd14;
  assign is_eq = key_valid && key_code == 5'd15;
  assign is_clr = key_valid && key_code == 5'd16;
  // Shift a digit into an operand; full operands and leading zeros leave it untouched.
  function automatic logic [18:0] push(input logic [15:0] v, input logic [2:0] c, input logic [3:0] k);
    return (c == 3'd4 || (c == 3'd0 && k == 4'd0)) ? {c, v} : {c + 3'd1, v[11:0], k};
  endfunction
  always_comb begin
    state_n = state;
    num1_n = num1;
    num2_n = num2;
    op_n = op;
    cnt_a_n = cnt_a;
    cnt_b_n = cnt_b;
    result_n = result;
    lat_n = lat;
    start_n = 1'b0;
    if (is_clr) begin
      state_n = ENTER_A;
      num1_n = '0;
      num2_n = '0;
      op_n = '0;
      cnt_a_n = '0;
      cnt_b_n = '0;
      result_n = '0;
      lat_n = '0;
    end else begin
      case (state)
        ENTER_A: begin
          if (is_digit) {cnt_a_n, num1_n} = push(num1, cnt_a, d);
          else if (is_op) begin
            op_n = 3'(key_code - 5'd10);
            num2_n = '0;
            cnt_b_n = '0;
            state_n = ENTER_B;
          end
        end
        ENTER_B: begin
          if (is_digit) {cnt_b_n, num2_n} = push(num2, cnt_b, d);
          else if (is_op && cnt_b == 3'd0) op_n = 3'(key_code - 5'd10);
          else if (is_eq) begin
            start_n = 1'b1;
            lat_n = '0;
            state_n = WAIT;
          end
        end
        WAIT: begin
          if (lat == 4'(ALU_LAT - 1)) begin
            result_n = res;
            lat_n = '0;
            state_n = SHOW;
          end else lat_n = lat + 4'd1;
        end
        default: begin
          if (is_digit) begin
            num1_n = {12'd0, d};
            cnt_a_n = (d != 4'd0) ? 3'd1 : 3'd0;
            state_n = ENTER_A;
          end else if (is_op) begin
            num1_n = result;
            op_n = 3'(key_code - 5'd10);
            num2_n = '0;
            cnt_b_n = '0;
            state_n = ENTER_B;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ENTER_A;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num1 <= '0;
      num2 <= '0;
      op <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      result <= '0;
      lat <= '0;
      start <= 1'b0;
    end else begin
      num1 <= num1_n;
      num2 <= num2_n;
      op <= op_n;
      cnt_a <= cnt_a_n;
      cnt_b <= cnt_b_n;
      result <= result_n;
      lat <= lat_n;
      start <= start_n;
    end
  end
  assign busy = state == WAIT;
  assign disp = state == ENTER_A ? num1 :
                state == ENTER_B ? (cnt_b != 3'd0 ? num2 : num1) :
                state == WAIT ? num2 : result;
endmodule

// File: tb/tb_calc_key_entry.sv
// tb_calc_key_entry: table-driven directed checks of calc_key_entry plus clear/reset corner sequences.
module tb_calc_key_entry;
  logic clk, rst, key_valid, start, busy;
  logic [4:0] key_code;
  logic [15:0] res, num1, num2, disp;
  logic [2:0] op;
  int n_checks = 0, n_fail = 0;

  calc_key_entry #(.ALU_LAT(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .res(res),
    .num1(num1), .num2(num2), .op(op), .start(start), .busy(busy), .disp(disp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] code; logic [15:0] r;
    logic [15:0] n1, n2; logic [2:0] o; logic st, bz; logic [15:0] dp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic v, input logic [4:0] code, input logic [15:0] r,
                     input logic [15:0] n1, input logic [15:0] n2, input logic [2:0] o,
                     input logic st, input logic bz, input logic [15:0] dp);
    vec_t e;
    e.v = v; e.code = code; e.r = r; e.n1 = n1; e.n2 = n2; e.o = o; e.st = st; e.bz = bz; e.dp = dp;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] n1, input logic [15:0] n2,
                         input logic [2:0] o, input logic st, input logic bz, input logic [15:0] dp);
    chk({tag, ".num1"}, num1, n1);
    chk({tag, ".num2"}, num2, n2);
    chk({tag, ".op"}, 16'(op), 16'(o));
    chk({tag, ".start"}, 16'(start), 16'(st));
    chk({tag, ".busy"}, 16'(busy), 16'(bz));
    chk({tag, ".disp"}, disp, dp);
  endtask

  task automatic press(input logic v, input logic [4:0] code, input logic [15:0] r);
    @(negedge clk);
    key_valid = v; key_code = code; res = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = '0; res = '0;
    // 1,4,div,7,= then latency 4 with res captured only on the expiry edge
    add(1, 1, 0, 16'h0001, 0, 0, 0, 0, 16'h0001);
    add(1, 4, 0, 16'h0014, 0, 0, 0, 0, 16'h0014);
    add(1, 13, 0, 16'h0014, 0, 3, 0, 0, 16'h0014);
    add(1, 7, 0, 16'h0014, 16'h0007, 3, 0, 0, 16'h0007);
    add(1, 15, 0, 16'h0014, 16'h0007, 3, 1, 1, 16'h0007);
    for (int i = 0; i < 3; i++) add(0, 0, 16'h1111, 16'h0014, 16'h0007, 3, 0, 1, 16'h0007);
    add(0, 0, 16'h0002, 16'h0014, 16'h0007, 3, 0, 0, 16'h0002);
    add(1, 16, 0, 0, 0, 0, 0, 0, 0);
    // five 9s saturate, sub, four 9s, =, clear during WAIT
    add(1, 9, 0, 16'h0009, 0, 0, 0, 0, 16'h0009);
    add(1, 9, 0, 16'h0099, 0, 0, 0, 0, 16'h0099);
    add(1, 9, 0, 16'h0999, 0, 0, 0, 0, 16'h0999);
    add(1, 9, 0, 16'h9999, 0, 0, 0, 0, 16'h9999);
    add(1, 9, 0, 16'h9999, 0, 0, 0, 0, 16'h9999);
    add(1, 11, 0, 16'h9999, 0, 1, 0, 0, 16'h9999);
    add(1, 9, 0, 16'h9999, 16'h0009, 1, 0, 0, 16'h0009);
    add(1, 9, 0, 16'h9999, 16'h0099, 1, 0, 0, 16'h0099);
    add(1, 9, 0, 16'h9999, 16'h0999, 1, 0, 0, 16'h0999);
    add(1, 9, 0, 16'h9999, 16'h9999, 1, 0, 0, 16'h9999);
    add(1, 15, 0, 16'h9999, 16'h9999, 1, 1, 1, 16'h9999);
    add(1, 16, 0, 0, 0, 0, 0, 0, 0);
    // invalid / unqualified keys, leading zeros, pow with zero operand, SHOW digit entry
    add(1, 20, 0, 0, 0, 0, 0, 0, 0);
    add(0, 5, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 8, 0, 16'h0008, 0, 0, 0, 0, 16'h0008);
    add(1, 14, 0, 16'h0008, 0, 4, 0, 0, 16'h0008);
    add(1, 0, 0, 16'h0008, 0, 4, 0, 0, 16'h0008);
    add(1, 15, 0, 16'h0008, 0, 4, 1, 1, 16'h0000);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 16'h0008, 0, 4, 0, 1, 16'h0000);
    add(0, 0, 16'h0512, 16'h0008, 0, 4, 0, 0, 16'h0512);
    add(1, 0, 0, 16'h0000, 0, 4, 0, 0, 16'h0000);
    add(1, 5, 0, 16'h0005, 0, 4, 0, 0, 16'h0005);
    add(1, 16, 0, 0, 0, 0, 0, 0, 0);
    // equals ignored in ENTER_A, operator replace/ignore, keys during WAIT, chained calc
    add(1, 15, 0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 0, 16'h0002, 0, 0, 0, 0, 16'h0002);
    add(1, 10, 0, 16'h0002, 0, 0, 0, 0, 16'h0002);
    add(1, 12, 0, 16'h0002, 0, 2, 0, 0, 16'h0002);
    add(1, 3, 0, 16'h0002, 16'h0003, 2, 0, 0, 16'h0003);
    add(1, 11, 0, 16'h0002, 16'h0003, 2, 0, 0, 16'h0003);
    add(1, 15, 0, 16'h0002, 16'h0003, 2, 1, 1, 16'h0003);
    add(1, 5, 0, 16'h0002, 16'h0003, 2, 0, 1, 16'h0003);
    add(1, 10, 0, 16'h0002, 16'h0003, 2, 0, 1, 16'h0003);
    add(1, 15, 0, 16'h0002, 16'h0003, 2, 0, 1, 16'h0003);
    add(1, 7, 16'h0006, 16'h0002, 16'h0003, 2, 0, 0, 16'h0006);
    add(1, 15, 0, 16'h0002, 16'h0003, 2, 0, 0, 16'h0006);
    add(1, 10, 0, 16'h0006, 0, 0, 0, 0, 16'h0006);
    add(1, 1, 0, 16'h0006, 16'h0001, 0, 0, 0, 16'h0001);
    add(1, 16, 0, 0, 0, 0, 0, 0, 0);

    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].v, tbl[i].code, tbl[i].r);
      chk_all($sformatf("vec%0d", i), tbl[i].n1, tbl[i].n2, tbl[i].o, tbl[i].st, tbl[i].bz, tbl[i].dp);
    end

    // clear on the expiry cycle wins over capture
    press(1, 1, 0); press(1, 10, 0); press(1, 2, 0); press(1, 15, 0);
    chk_all("clrexp.start", 16'h0001, 16'h0002, 0, 1, 1, 16'h0002);
    for (int i = 0; i < 3; i++) press(0, 0, 16'h1234);
    press(1, 16, 16'h1234);
    chk_all("clrexp.after", 0, 0, 0, 0, 0, 0);
    press(0, 0, 16'h1234);
    chk_all("clrexp.idle", 0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-WAIT
    press(1, 1, 0); press(1, 10, 0); press(1, 2, 0); press(1, 15, 0);
    press(0, 0, 16'h4321);
    chk_all("rstwait.pre", 16'h0001, 16'h0002, 0, 0, 1, 16'h0002);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("rstwait.async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rstwait.release", 0, 0, 0, 0, 0, 0);
    press(1, 3, 0);
    chk_all("rstwait.digit", 16'h0003, 0, 0, 0, 0, 16'h0003);

    key_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
